// File: rtl/frame_mixer.sv
// Round-robin frame mixer: merges frames from NPORTS first-word-fall-through FIFOs into one output FIFO,
// never interleaving frames, with optional high-priority ports and an in-frame stall timeout.
module frame_mixer #(
  parameter int                NPORTS     = 6,
  parameter int                DW         = 9,
  parameter logic [NPORTS-1:0] HIPRI_MASK = '0,
  parameter int                TIMEOUT    = 1024
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NPORTS*DW-1:0] in_dout,
  input  logic [NPORTS-1:0]    in_empty,
  output logic [NPORTS-1:0]    in_rd_en,
  output logic [DW-1:0]        out_din,
  input  logic                 out_full,
  output logic                 out_wr_en,
  output logic [NPORTS-1:0]    cur_grant,
  output logic                 err_timeout
);

  localparam int IW = $clog2(NPORTS);
  localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STALL_LIMIT = SW'(TIMEOUT);
  localparam logic [IW-1:0] LAST_PORT   = IW'(NPORTS - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state, state_next;
  logic [IW-1:0]     grant_idx, last_idx, pick_idx, cand;
  logic              pick_valid;
  logic              seen_data;
  logic [SW-1:0]     stall_cnt;
  logic [DW-1:0]     words [NPORTS];
  logic [DW-1:0]     cur_word;
  logic [NPORTS-1:0] hi_req, lo_req, sel_req;
  logic              cur_empty, timeout_hit, abort, pop, terminator, drop;

  for (genvar p = 0; p < NPORTS; p++) begin : g_unpack
    assign words[p] = in_dout[p*DW +: DW];
  end

  assign cur_word  = words[grant_idx];
  assign cur_empty = in_empty[grant_idx];

  // High-priority requesters hide all others; search begins just after the last served port.
  always_comb begin
    hi_req     = ~in_empty & HIPRI_MASK;
    lo_req     = ~in_empty & ~HIPRI_MASK;
    sel_req    = (|hi_req) ? hi_req : lo_req;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NPORTS; i++) begin
      cand = IW'((int'(last_idx) + i) % NPORTS);
      if (!pick_valid && sel_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    timeout_hit = (TIMEOUT != 0) && seen_data && (stall_cnt >= STALL_LIMIT);
    abort       = (state == XFER) && timeout_hit && !out_full;
    pop         = (state == XFER) && !cur_empty && !out_full && !abort;
    terminator  = pop && !cur_word[DW-1] && seen_data;
    drop        = (state == XFER) && cur_empty && !out_full && !seen_data;
    state_next  = state;
    in_rd_en    = '0;
    case (state)
      IDLE: if (pick_valid) state_next = XFER;
      XFER: if (abort || terminator || drop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (pop && !sys_rst) in_rd_en[grant_idx] = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      out_din     <= '0;
      out_wr_en   <= 1'b0;
      err_timeout <= 1'b0;
      cur_grant   <= '0;
      grant_idx   <= '0;
      last_idx    <= LAST_PORT;
      seen_data   <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      out_wr_en   <= 1'b0;
      err_timeout <= 1'b0;
      if (state == IDLE) begin
        if (pick_valid) begin
          grant_idx <= pick_idx;
          cur_grant <= NPORTS'(1) << pick_idx;
          seen_data <= 1'b0;
          stall_cnt <= '0;
        end
      end else if (abort) begin
        out_din     <= '0;
        out_wr_en   <= 1'b1;
        err_timeout <= 1'b1;
        cur_grant   <= '0;
        last_idx    <= grant_idx;
        seen_data   <= 1'b0;
        stall_cnt   <= '0;
      end else if (pop) begin
        out_din   <= cur_word;
        out_wr_en <= 1'b1;
        stall_cnt <= '0;
        if (cur_word[DW-1]) begin
          seen_data <= 1'b1;
        end else if (seen_data) begin
          cur_grant <= '0;
          last_idx  <= grant_idx;
          seen_data <= 1'b0;
        end
      end else if (drop) begin
        cur_grant <= '0;
      end else if (seen_data && !out_full && stall_cnt != '1) begin
        // Full output stalls are back-pressure, not a silent source, so they do not count.
        stall_cnt <= stall_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_mixer.sv
// Self-checking bench for frame_mixer: FIFO models feed two instances (default and high-priority/short-timeout),
// with an arbitration vector table, directed multi-cycle sequences and randomized frames against a frame-level model.
module tb_frame_mixer;

  localparam int NP    = 6;
  localparam int DW    = 9;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] full = 2'b00;

  logic [NP*DW-1:0] dout_a, dout_b;
  logic [NP-1:0]    empty_a, empty_b, rd_a, rd_b, grant_a, grant_b;
  logic [DW-1:0]    din_a, din_b;
  logic             wr_a, wr_b, err_a, err_b;

  always #5 clk = ~clk;

  frame_mixer #(.NPORTS(NP), .DW(DW), .HIPRI_MASK(6'b000000), .TIMEOUT(1024)) dut_main (
    .sys_clk(clk), .sys_rst(rst), .in_dout(dout_a), .in_empty(empty_a), .in_rd_en(rd_a),
    .out_din(din_a), .out_full(full[0]), .out_wr_en(wr_a), .cur_grant(grant_a), .err_timeout(err_a));

  frame_mixer #(.NPORTS(NP), .DW(DW), .HIPRI_MASK(6'b100000), .TIMEOUT(16)) dut_alt (
    .sys_clk(clk), .sys_rst(rst), .in_dout(dout_b), .in_empty(empty_b), .in_rd_en(rd_b),
    .out_din(din_b), .out_full(full[1]), .out_wr_en(wr_b), .cur_grant(grant_b), .err_timeout(err_b));

  // Input FIFO models: words are pushed by the test, popped on the DUT's read strobe.
  logic [DW-1:0] mem [2][NP][DEPTH];
  int wp [2][NP];
  int rp [2][NP];

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      empty_a[p]           = (wp[0][p] == rp[0][p]);
      empty_b[p]           = (wp[1][p] == rp[1][p]);
      dout_a[p*DW +: DW]   = mem[0][p][rp[0][p] % DEPTH];
      dout_b[p*DW +: DW]   = mem[1][p][rp[1][p] % DEPTH];
    end
  end

  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (rd_a[p]) rp[0][p] <= rp[0][p] + 1;
      if (rd_b[p]) rp[1][p] <= rp[1][p] + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: logs every write with its cycle, error pulses and illegal pops.
  logic [DW-1:0] obs0 [$];
  logic [DW-1:0] obs1 [$];
  int ocyc0 [$];
  int ocyc1 [$];
  int errs [2];
  int errcyc [2];
  int pop_bad [2];

  always @(negedge clk) begin
    if (wr_a) begin obs0.push_back(din_a); ocyc0.push_back(cyc); end
    if (wr_b) begin obs1.push_back(din_b); ocyc1.push_back(cyc); end
    if (err_a) begin errs[0]++; errcyc[0] = cyc; end
    if (err_b) begin errs[1]++; errcyc[1] = cyc; end
    if (((rd_a != 0) && full[0]) || ((rd_a & empty_a) != 0) || ($countones(rd_a) > 1)) pop_bad[0]++;
    if (((rd_b != 0) && full[1]) || ((rd_b & empty_b) != 0) || ($countones(rd_b) > 1)) pop_bad[1]++;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NP-1:0] grantOf(input int k);
    return (k == 0) ? grant_a : grant_b;
  endfunction

  function automatic logic [DW-1:0] dinOf(input int k);
    return (k == 0) ? din_a : din_b;
  endfunction

  function automatic logic wrOf(input int k);
    return (k == 0) ? wr_a : wr_b;
  endfunction

  function automatic int obsSize(input int k);
    return (k == 0) ? obs0.size() : obs1.size();
  endfunction

  function automatic logic [DW-1:0] obsAt(input int k, input int i);
    return (k == 0) ? obs0[i] : obs1[i];
  endfunction

  function automatic int ocycAt(input int k, input int i);
    return (k == 0) ? ocyc0[i] : ocyc1[i];
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int k, input int p, input logic [DW-1:0] w);
    mem[k][p][wp[k][p] % DEPTH] = w;
    wp[k][p] = wp[k][p] + 1;
  endtask

  task automatic clearLogs();
    obs0.delete(); obs1.delete(); ocyc0.delete(); ocyc1.delete();
    for (int k = 0; k < 2; k++) begin
      errs[k] = 0; errcyc[k] = 0; pop_bad[k] = 0;
    end
  endtask

  task automatic doReset();
    rst  = 1'b1;
    full = 2'b00;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++) wp[k][p] = rp[k][p];
    step(2);
    rst = 1'b0;
    clearLogs();
  endtask

  task automatic checkStream(input string name, input int k, input logic [DW-1:0] exp [$]);
    checkOutput({name, "_count"}, obsSize(k), exp.size());
    for (int i = 0; i < exp.size() && i < obsSize(k); i++)
      checkOutput($sformatf("%s_word%0d", name, i), obsAt(k, i), exp[i]);
  endtask

  typedef struct {
    int            inst;
    logic [NP-1:0] load;
    int            port;
  } arb_vec_t;

  task automatic applyStimulus(input arb_vec_t v);
    for (int p = 0; p < NP; p++)
      if (v.load[p]) push(v.inst, p, DW'(p));
  endtask

  task automatic runTable();
    arb_vec_t vecs [11];
    vecs[0]  = '{0, 6'b000001, 0};
    vecs[1]  = '{0, 6'b000100, 2};
    vecs[2]  = '{0, 6'b101000, 3};
    vecs[3]  = '{0, 6'b110000, 4};
    vecs[4]  = '{0, 6'b100000, 5};
    vecs[5]  = '{0, 6'b111111, 0};
    vecs[6]  = '{0, 6'b011110, 1};
    vecs[7]  = '{1, 6'b100001, 5};
    vecs[8]  = '{1, 6'b000110, 1};
    vecs[9]  = '{1, 6'b011000, 3};
    vecs[10] = '{1, 6'b111110, 5};
    for (int i = 0; i < 11; i++) begin
      doReset();
      applyStimulus(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_grant", i), grantOf(vecs[i].inst), NP'(1) << vecs[i].port);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_wr", i), wrOf(vecs[i].inst), 1);
      checkOutput($sformatf("tbl%0d_din", i), dinOf(vecs[i].inst), DW'(vecs[i].port));
    end
  endtask

  task automatic testTwoFrames();
    logic [DW-1:0] exp [$];
    int c0;
    int ecyc [8] = '{2, 3, 4, 5, 7, 8, 9, 10};
    doReset();
    c0 = cyc;
    exp = '{9'h1AA, 9'h1BB, 9'h1CC, 9'h000, 9'h1AA, 9'h1BB, 9'h1CC, 9'h000};
    for (int i = 0; i < 4; i++) begin
      push(0, 0, exp[i]);
      push(0, 2, exp[i]);
    end
    repeat (2) @(negedge clk);
    checkOutput("two_grant_p0", grant_a, 6'b000001);
    repeat (4) @(negedge clk);
    checkOutput("two_bubble_grant", grant_a, 6'b000000);
    @(negedge clk);
    checkOutput("two_grant_p2", grant_a, 6'b000100);
    step(10);
    checkStream("two", 0, exp);
    for (int i = 0; i < 8 && i < obs0.size(); i++)
      checkOutput($sformatf("two_cyc%0d", i), ocycAt(0, i) - c0, ecyc[i]);
  endtask

  task automatic testHipri();
    logic [DW-1:0] exp [$];
    doReset();
    push(1, 0, 9'h1A0); push(1, 0, 9'h000);
    push(1, 5, 9'h1A5); push(1, 5, 9'h000);
    repeat (2) @(negedge clk);
    checkOutput("hipri_grant_p5", grant_b, 6'b100000);
    step(10);
    exp = '{9'h1A5, 9'h000, 9'h1A0, 9'h000};
    checkStream("hipri", 1, exp);
    push(1, 0, 9'h1B0); push(1, 0, 9'h000);
    push(1, 1, 9'h1B1); push(1, 1, 9'h000);
    repeat (2) @(negedge clk);
    checkOutput("hipri_rr_p1", grant_b, 6'b000010);
    step(10);
  endtask

  task automatic testHold();
    logic [DW-1:0] exp [$];
    int bad;
    doReset();
    push(0, 1, 9'h101); push(0, 1, 9'h102);
    push(0, 3, 9'h1C3); push(0, 3, 9'h000);
    step(3);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (grant_a != 6'b000010 || rd_a[3]) bad++;
    end
    checkOutput("hold_bad_cycles", bad, 0);
    step(1);
    push(0, 1, 9'h000);
    step(12);
    exp = '{9'h101, 9'h102, 9'h000, 9'h1C3, 9'h000};
    checkStream("hold", 0, exp);
    checkOutput("hold_no_err", errs[0], 0);
  endtask

  task automatic testTimeout();
    logic [DW-1:0] exp [$];
    int c0;
    doReset();
    c0 = cyc;
    push(1, 0, 9'h1FF);
    step(25);
    exp = '{9'h1FF, 9'h000};
    checkStream("tmo", 1, exp);
    if (obs1.size() >= 2) checkOutput("tmo_abort_cyc", ocycAt(1, 1) - c0, 19);
    checkOutput("tmo_err_pulses", errs[1], 1);
    checkOutput("tmo_err_cyc", errcyc[1] - c0, 19);
    checkOutput("tmo_grant_idle", grant_b, 0);
    push(1, 0, 9'h1D0); push(1, 0, 9'h000);
    push(1, 1, 9'h1D1); push(1, 1, 9'h000);
    repeat (2) @(negedge clk);
    checkOutput("tmo_next_p1", grant_b, 6'b000010);
    step(10);
  endtask

  task automatic testBackpressure();
    logic [DW-1:0] exp [$];
    doReset();
    for (int i = 0; i < 63; i++) exp.push_back({1'b1, 8'($urandom)});
    exp.push_back({1'b0, 8'($urandom)});
    for (int i = 0; i < 64; i++) push(0, 0, exp[i]);
    for (int i = 0; i < 160; i++) begin
      full[0] = i[0];
      step(1);
    end
    full[0] = 1'b0;
    step(4);
    checkStream("bp", 0, exp);
    checkOutput("bp_illegal_pops", pop_bad[0], 0);
  endtask

  task automatic testMidReset();
    logic [DW-1:0] exp [$];
    doReset();
    push(0, 0, 9'h1A1); push(0, 0, 9'h1A2); push(0, 0, 9'h1A3);
    push(0, 0, 9'h1A4); push(0, 0, 9'h1A5); push(0, 0, 9'h000);
    push(0, 1, 9'h1B1); push(0, 1, 9'h000);
    step(3);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_rd_en", rd_a, 0);
    step(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_grant", grant_a, 0);
    checkOutput("rst_wr", wr_a, 0);
    checkOutput("rst_din", din_a, 0);
    checkOutput("rst_err", err_a, 0);
    checkOutput("rst_writes_before", obs0.size(), 2);
    @(negedge clk);
    checkOutput("rst_first_p0", grant_a, 6'b000001);
    step(14);
    exp = '{9'h1A1, 9'h1A2, 9'h1A3, 9'h1A4, 9'h1A5, 9'h000, 9'h1B1, 9'h000};
    checkStream("rst", 0, exp);
  endtask

  // Frame-level reference: whole frames are served in round-robin order with high-priority ports first.
  task automatic runRandom(input int k, input int rounds);
    logic [DW-1:0] fw [NP][2][6];
    int            fl [NP][2];
    int            nf [NP];
    int            fidx [NP];
    logic [DW-1:0] expq [$];
    logic [NP-1:0] hmask, avail, sel;
    int            last, pick, total, budget;
    for (int r = 0; r < rounds; r++) begin
      doReset();
      hmask = (k == 0) ? 6'b000000 : 6'b100000;
      total = 0;
      for (int p = 0; p < NP; p++) begin
        nf[p]   = $urandom_range(0, 2);
        fidx[p] = 0;
        for (int f = 0; f < nf[p]; f++) begin
          fl[p][f] = $urandom_range(2, 6);
          for (int w = 0; w < fl[p][f] - 1; w++) fw[p][f][w] = {1'b1, 8'($urandom)};
          fw[p][f][fl[p][f] - 1] = {1'b0, 8'($urandom)};
        end
        total += nf[p];
      end
      if (total == 0) begin
        pick = $urandom_range(0, NP - 1);
        nf[pick] = 1; fl[pick][0] = 2;
        fw[pick][0][0] = {1'b1, 8'($urandom)};
        fw[pick][0][1] = {1'b0, 8'($urandom)};
      end
      for (int p = 0; p < NP; p++)
        for (int f = 0; f < nf[p]; f++)
          for (int w = 0; w < fl[p][f]; w++) push(k, p, fw[p][f][w]);
      expq.delete();
      last = NP - 1;
      for (int guard = 0; guard < 2 * NP; guard++) begin
        for (int p = 0; p < NP; p++) avail[p] = (fidx[p] < nf[p]);
        if (avail == 0) break;
        sel  = ((avail & hmask) != 0) ? (avail & hmask) : (avail & ~hmask);
        pick = -1;
        for (int i = 1; i <= NP; i++)
          if (pick < 0 && sel[(last + i) % NP]) pick = (last + i) % NP;
        for (int w = 0; w < fl[pick][fidx[pick]]; w++) expq.push_back(fw[pick][fidx[pick]][w]);
        fidx[pick]++;
        last = pick;
      end
      budget = 0;
      while (obsSize(k) < expq.size() && budget < 600) begin
        full[k] = ($urandom_range(0, 3) == 0);
        step(1);
        budget++;
      end
      full[k] = 1'b0;
      step(4);
      checkStream($sformatf("rand%0d_%0d", k, r), k, expq);
      checkOutput($sformatf("rand%0d_%0d_illegal_pops", k, r), pop_bad[k], 0);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    full = 2'b00;
    push(0, 0, 9'h1EE);
    push(1, 5, 9'h1EE);
    step(3);
    @(negedge clk);
    checkOutput("reset_grant_main", grant_a, 0);
    checkOutput("reset_grant_alt", grant_b, 0);
    checkOutput("reset_wr_main", wr_a, 0);
    checkOutput("reset_din_main", din_a, 0);
    checkOutput("reset_err_main", err_a, 0);
    checkOutput("reset_rd_main", rd_a, 0);
    checkOutput("reset_rd_alt", rd_b, 0);
    $display("[TB] arbitration table");
    runTable();
    $display("[TB] directed sequences");
    testTwoFrames();
    testHipri();
    testHold();
    testTimeout();
    testBackpressure();
    testMidReset();
    $display("[TB] randomized frames");
    runRandom(0, 4);
    runRandom(1, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_mixer.md
FRAME_MIXER -- requirements
Module: frame_mixer

Interface
REQ-001 SHALL have parameter NPORTS, default 6, meaning number of input ports (2..8).
REQ-002 SHALL have parameter DW, default 9, meaning word width; bit DW-1 is the frame flag (1 = frame data, 0 = gap/terminator).
REQ-003 SHALL have parameter HIPRI_MASK, default 0, meaning an NPORTS-bit mask of ports that win arbitration over all unmasked ports.
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning the stall cycles allowed inside a frame before abort; 0 disables the abort.
REQ-005 SHALL have port sys_clk  input  1  sole clock, all logic on the rising edge.
REQ-006 SHALL have port sys_rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_dout  input  NPORTS*DW  first-word-fall-through FIFO data; port p occupies bits [p*DW+DW-1:p*DW].
REQ-008 SHALL have port in_empty  input  NPORTS  per-port FIFO empty.
REQ-009 SHALL have port in_rd_en  output  NPORTS  per-port pop, combinational, at most one bit high.
REQ-010 SHALL have port out_din  output  DW  registered output word.
REQ-011 SHALL have port out_full  input  1  output FIFO programmable-full, asserted while at most 1 slot is free.
REQ-012 SHALL have port out_wr_en  output  1  registered output write strobe.
REQ-013 SHALL have port cur_grant  output  NPORTS  one-hot granted port, 0 when idle.
REQ-014 SHALL have port err_timeout  output  1  one-cycle pulse on a frame abort.

Function
REQ-015 SHALL implement states IDLE and XFER.
REQ-016 In IDLE with any in_empty bit low, SHALL register a grant: first the round-robin winner among non-empty HIPRI_MASK ports, else among the other non-empty ports; the search starts at the port after the last granted port. It SHALL then enter XFER.
REQ-017 In XFER, in_rd_en[g] SHALL equal (!in_empty[g] && !out_full && !abort) for the granted port g only.
REQ-018 Every pop SHALL produce out_din <= popped word and out_wr_en <= 1 on the next edge; out_wr_en SHALL be 0 in every other cycle except an abort.
REQ-019 Throughput SHALL be one word per cycle. First-word latency SHALL be 2 cycles from IDLE seeing !in_empty to out_wr_en (grant at +1, write at +2).
REQ-020 A seen_data flag SHALL set on a popped word with flag=1.
REQ-021 A popped word with flag=0 while seen_data=1 is the terminator. It SHALL be forwarded, and the block SHALL clear seen_data, clear cur_grant, record g as last granted, and return to IDLE.
REQ-022 Leading flag=0 words (seen_data=0) SHALL be forwarded.
REQ-023 If the granted FIFO is empty while seen_data=0, the block SHALL return to IDLE with no output.
REQ-024 If the granted FIFO empties while seen_data=1, the grant SHALL be held; the block SHALL never switch ports mid-frame.
REQ-025 A stall counter SHALL count consecutive XFER cycles without a pop while seen_data=1, and SHALL clear on each pop.
REQ-026 When TIMEOUT!=0 and the stall counter reaches TIMEOUT, the block SHALL abort on the next cycle with !out_full:
- write out_din = 0 with out_wr_en = 1;
- pulse err_timeout for 1 cycle;
- return to IDLE and advance the round-robin pointer past g.
REQ-027 out_full high SHALL suppress all pops and the abort write, with no data loss and no state change.
REQ-028 After returning to IDLE, the next grant SHALL occur one cycle later, giving a 1-cycle bubble between frames.
REQ-029 The stall counter SHALL be clog2(TIMEOUT+1) bits wide and SHALL saturate.

Reset
REQ-030 sys_rst SHALL force IDLE; out_wr_en, err_timeout and cur_grant = 0; out_din = 0; seen_data and the stall counter = 0; last granted = NPORTS-1, so port 0 has first priority.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no terminator; in_rd_en SHALL be 0 during reset.

Verification
REQ-032 Ports 0 and 2 each hold a 4-word frame (0x1AA, 0x1BB, 0x1CC, 0x000) -> port 0's frame is output first, port 2's frame after one idle cycle, 8 writes in total, words in order.
REQ-033 HIPRI_MASK=6'b100000; ports 0 and 5 are loaded at once -> port 5 is granted first; a later simultaneous load of ports 0 and 1 after port 0 was served -> port 1 is granted.
REQ-034 Port 1 sends 0x101, 0x102 and then goes empty for 50 cycles while port 3 has data -> cur_grant stays at port 1, no port-3 pop; the port-1 terminator then completes the frame.
REQ-035 TIMEOUT=16; port 0 sends 0x1FF and then stays empty -> after 16 stall cycles, out_din=0x000 is written once, err_timeout pulses once, and the next grant goes to port 1.
REQ-036 out_full toggles every other cycle during a 64-word frame -> exactly 64 writes, order preserved, no pop while out_full=1.
REQ-037 sys_rst asserted on the third word of a frame -> all outputs 0 the next cycle; after release, port 0 is arbitrated first.
